// File: rtl/regfile_alu_datapath.sv
// Register file (2^SEL_WIDTH x BIT_WIDTH) with a single-cycle ALU, flag register and registered readout.
// Define REGFILE_BYPASS_EN for write-first forwarding of the readout port; otherwise the readout is read-first.
module regfile_alu_datapath #(
    parameter int unsigned BIT_WIDTH    = 16,
    parameter int unsigned SEL_WIDTH    = 4,
    parameter int unsigned OPCODE_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SEL_WIDTH-1:0]    SrcAddr,
    input  logic [SEL_WIDTH-1:0]    DestAddr,
    input  logic [SEL_WIDTH-1:0]    WriteAddr,
    input  logic                    regReset,
    input  logic                    regWriteEn,
    input  logic                    ImmMuxSel,
    input  logic [BIT_WIDTH-1:0]    ImmData,
    input  logic [OPCODE_WIDTH-1:0] op,
    output logic [BIT_WIDTH-1:0]    ReadData,
    output logic [BIT_WIDTH-1:0]    AluOut,
    output logic [4:0]              Flags
);

    localparam int unsigned NREGS = 2 ** SEL_WIDTH;
    localparam int unsigned MSB   = BIT_WIDTH - 1;

    localparam logic [OPCODE_WIDTH-1:0] OP_AND  = OPCODE_WIDTH'(8'h01);
    localparam logic [OPCODE_WIDTH-1:0] OP_OR   = OPCODE_WIDTH'(8'h02);
    localparam logic [OPCODE_WIDTH-1:0] OP_XOR  = OPCODE_WIDTH'(8'h03);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(8'h05);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(8'h09);
    localparam logic [OPCODE_WIDTH-1:0] OP_CMP  = OPCODE_WIDTH'(8'h0B);
    localparam logic [OPCODE_WIDTH-1:0] OP_MOV  = OPCODE_WIDTH'(8'h0D);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(8'h50);
    localparam logic [OPCODE_WIDTH-1:0] OP_LSHI = OPCODE_WIDTH'(8'h80);
    localparam logic [OPCODE_WIDTH-1:0] OP_LSH  = OPCODE_WIDTH'(8'h84);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(8'h90);
    localparam logic [OPCODE_WIDTH-1:0] OP_MOVI = OPCODE_WIDTH'(8'hD0);

    typedef enum logic [3:0] {
        CLS_NONE,
        CLS_ADD,
        CLS_SUB,
        CLS_CMP,
        CLS_AND,
        CLS_OR,
        CLS_XOR,
        CLS_MOV,
        CLS_LSH
    } op_class_e;

    // Flag bit positions within {C, L, F, Z, N}
    localparam int unsigned FL_C = 4;
    localparam int unsigned FL_L = 3;
    localparam int unsigned FL_F = 2;
    localparam int unsigned FL_Z = 1;
    localparam int unsigned FL_N = 0;

    logic [BIT_WIDTH-1:0] regs_q [NREGS];
    logic [BIT_WIDTH-1:0] regs_d [NREGS];
    logic [4:0]           flags_q, flags_d;
    logic [BIT_WIDTH-1:0] readdata_q, readdata_d;

    op_class_e            op_cls;
    logic [BIT_WIDTH-1:0] opa, opb;
    logic [BIT_WIDTH:0]   sum_ext, diff_ext;
    logic                 ovf_add, ovf_sub;
    logic [4:0]           sh_amt, sh_neg;
    logic [BIT_WIDTH-1:0] alu_res;
    logic                 is_arith;
    logic                 commit, wr_en;

    always_comb begin
        op_cls = CLS_NONE;
        case (op)
            OP_ADD, OP_ADDI: op_cls = CLS_ADD;
            OP_SUB, OP_SUBI: op_cls = CLS_SUB;
            OP_CMP:          op_cls = CLS_CMP;
            OP_AND:          op_cls = CLS_AND;
            OP_OR:           op_cls = CLS_OR;
            OP_XOR:          op_cls = CLS_XOR;
            OP_MOV, OP_MOVI: op_cls = CLS_MOV;
            OP_LSH, OP_LSHI: op_cls = CLS_LSH;
            default:         op_cls = CLS_NONE;
        endcase
    end

    assign opa = regs_q[DestAddr];
    assign opb = ImmMuxSel ? ImmData : regs_q[SrcAddr];

    assign sum_ext  = {1'b0, opa} + {1'b0, opb};
    assign diff_ext = {1'b0, opa} - {1'b0, opb};
    assign ovf_add  = (opa[MSB] == opb[MSB]) && (sum_ext[MSB] != opa[MSB]);
    assign ovf_sub  = (opa[MSB] != opb[MSB]) && (diff_ext[MSB] != opa[MSB]);

    // Shift count is a 5-bit signed field; negative counts shift right by the magnitude (-16 clears).
    assign sh_amt = opb[4:0];
    assign sh_neg = -sh_amt;

    always_comb begin
        alu_res = '0;
        case (op_cls)
            CLS_ADD:          alu_res = sum_ext[BIT_WIDTH-1:0];
            CLS_SUB, CLS_CMP: alu_res = diff_ext[BIT_WIDTH-1:0];
            CLS_AND:          alu_res = opa & opb;
            CLS_OR:           alu_res = opa | opb;
            CLS_XOR:          alu_res = opa ^ opb;
            CLS_MOV:          alu_res = opb;
            CLS_LSH:          alu_res = sh_amt[4] ? (opa >> sh_neg) : (opa << sh_amt[3:0]);
            default:          alu_res = '0;
        endcase
    end

    assign AluOut   = alu_res;
    assign is_arith = (op_cls == CLS_ADD) || (op_cls == CLS_SUB) || (op_cls == CLS_CMP);
    assign commit   = regWriteEn && (op_cls != CLS_NONE);
    assign wr_en    = commit && (op_cls != CLS_CMP);

    always_comb begin
        regs_d = regs_q;
        if (regReset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_d[i] = '0;
            end
        end else if (wr_en) begin
            regs_d[WriteAddr] = alu_res;
        end
    end

    always_comb begin
        flags_d = flags_q;
        if (regReset) begin
            flags_d = '0;
        end else if (commit) begin
            flags_d[FL_Z] = (alu_res == '0);
            flags_d[FL_N] = alu_res[MSB];
            if (is_arith) begin
                flags_d[FL_C] = (op_cls == CLS_ADD) ? sum_ext[BIT_WIDTH] : diff_ext[BIT_WIDTH];
                flags_d[FL_L] = diff_ext[BIT_WIDTH];
                flags_d[FL_F] = (op_cls == CLS_ADD) ? ovf_add : ovf_sub;
            end
        end
    end

    always_comb begin
        readdata_d = regs_q[SrcAddr];
        if (regReset) begin
            readdata_d = '0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (wr_en && (WriteAddr == SrcAddr)) begin
            readdata_d = alu_res;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            flags_q    <= '0;
            readdata_q <= '0;
        end else begin
            regs_q     <= regs_d;
            flags_q    <= flags_d;
            readdata_q <= readdata_d;
        end
    end

    assign ReadData = readdata_q;
    assign Flags    = flags_q;

endmodule

// File: tb/tb_regfile_alu_datapath.sv
// Bench for regfile_alu_datapath: directed steps followed by random control words against an arithmetic model.
// Expectations for same-edge write/readout follow REGFILE_BYPASS_EN.
module tb_regfile_alu_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  src, dst, wa;
    logic        rr, we, ims;
    logic [15:0] imm;
    logic [7:0]  opc;
    logic [15:0] ReadData, AluOut;
    logic [4:0]  Flags;

    int n_assert = 0;
    int n_fail   = 0;

    int unsigned mreg [16];
    bit mc, ml, mf, mz, mn;

    logic [7:0] ops [14] = '{8'h05, 8'h50, 8'h09, 8'h90, 8'h0B, 8'h01, 8'h02,
                             8'h03, 8'h0D, 8'hD0, 8'h84, 8'h80, 8'h00, 8'hFF};

    always #5 clk = ~clk;

    regfile_alu_datapath #(
        .BIT_WIDTH(16),
        .SEL_WIDTH(4),
        .OPCODE_WIDTH(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .SrcAddr(src),
        .DestAddr(dst),
        .WriteAddr(wa),
        .regReset(rr),
        .regWriteEn(we),
        .ImmMuxSel(ims),
        .ImmData(imm),
        .op(opc),
        .ReadData(ReadData),
        .AluOut(AluOut),
        .Flags(Flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sgn(input int unsigned x);
        return (x >= 32768) ? int'(x) - 65536 : int'(x);
    endfunction

    function automatic bit out_of_range(input int v);
        return (v > 32767) || (v < -32768);
    endfunction

    // Architectural result of one control word, from the opcode table.
    function automatic void model_alu(input int unsigned a, input int unsigned b, input logic [7:0] o,
                                      output int unsigned r, output bit valid, output bit is_cmp,
                                      output bit arith, output bit c, output bit l, output bit f);
        int unsigned s;
        r = 0; valid = 1; is_cmp = 0; arith = 0; c = 0; l = 0; f = 0;
        case (o)
            8'h05, 8'h50: begin
                r = (a + b) % 65536; arith = 1; c = (a + b) > 65535; l = a < b;
                f = out_of_range(sgn(a) + sgn(b));
            end
            8'h09, 8'h90, 8'h0B: begin
                r = (a + 65536 - b) % 65536; arith = 1; c = a < b; l = a < b;
                f = out_of_range(sgn(a) - sgn(b)); is_cmp = (o == 8'h0B);
            end
            8'h01: r = a & b;
            8'h02: r = a | b;
            8'h03: r = a ^ b;
            8'h0D, 8'hD0: r = b;
            8'h84, 8'h80: begin
                s = b % 32;
                if (s < 16) r = (a * (32'd1 << s)) % 65536;
                else        r = a / (32'd1 << (32 - s));
            end
            default: valid = 0;
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mreg[i] = 0;
        {mc, ml, mf, mz, mn} = '0;
    endtask

    // Applies one control word at posedge+1, checks AluOut before the edge, ReadData/Flags after it.
    task automatic step(input logic [7:0] o, input int d, input int s, input int w, input bit im,
                        input int unsigned iv, input bit we_v, input bit rr_v);
        int unsigned a, b, r;
        bit v, cmp, ar, c, l, f, wr;
        logic [15:0] exp_rd;
        opc = o; dst = 4'(d); src = 4'(s); wa = 4'(w); ims = im; imm = 16'(iv); we = we_v; rr = rr_v;
        a = mreg[d];
        b = im ? (iv % 65536) : mreg[s];
        model_alu(a, b, o, r, v, cmp, ar, c, l, f);
        #1;
        chk("aluout", 32'(AluOut), r);
        wr = we_v && v && !cmp && !rr_v;
        exp_rd = 16'(mreg[s]);
        if (rr_v) exp_rd = '0;
`ifdef REGFILE_BYPASS_EN
        else if (wr && (w == s)) exp_rd = 16'(r);
`endif
        @(posedge clk);
        if (rr_v) begin
            model_clear();
        end else if (we_v && v) begin
            if (!cmp) mreg[w] = r;
            mz = (r == 0);
            mn = (r >= 32768);
            if (ar) begin mc = c; ml = l; mf = f; end
        end
        #1;
        chk("readdata", 32'(ReadData), 32'(exp_rd));
        chk("flags", 32'(Flags), 32'({mc, ml, mf, mz, mn}));
    endtask

    initial begin
        reset = 1'b1;
        {src, dst, wa, rr, we, ims, imm, opc} = '0;
        model_clear();
        #1;
        chk("reset_readdata", 32'(ReadData), 0);
        chk("reset_flags", 32'(Flags), 0);
        chk("reset_aluout", 32'(AluOut), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // ADDI R0 = R0 + 1
        step(8'h50, 0, 0, 0, 1, 1, 1, 0);
        chk("addi_c", 32'(Flags[4]), 0);
        chk("addi_z", 32'(Flags[1]), 0);
        step(8'h00, 0, 0, 0, 0, 0, 0, 0);
        chk("addi_r0", 32'(ReadData), 1);

        // Shift chain R[n] = R[n-1] << 1, then sweep readout
        for (int n = 1; n < 16; n++) step(8'h80, n - 1, 0, n, 1, 1, 1, 0);
        for (int i = 0; i < 16; i++) begin
            step(8'h00, 0, i, 0, 0, 0, 0, 0);
            chk("sweep", 32'(ReadData), 32'd1 << i);
        end

        // 0x8000 + 0x8000 wraps: C, F, Z
        step(8'hD0, 0, 0, 1, 1, 'h8000, 1, 0);
        step(8'h05, 1, 1, 2, 0, 0, 1, 0);
        chk("add_wrap_flags", 32'(Flags), 32'(5'b10110));
        step(8'hD0, 0, 0, 3, 1, 3, 1, 0);
        step(8'h0B, 3, 4, 4, 1, 5, 1, 0);
        chk("cmp_flags", 32'(Flags), 32'(5'b11001));
        step(8'h00, 0, 4, 0, 0, 0, 0, 0);
        chk("cmp_nowrite", 32'(ReadData), 32'h0010);

        // Negative shift counts
        step(8'hD0, 0, 0, 6, 1, 'h8001, 1, 0);
        step(8'h80, 6, 0, 7, 1, 'h1F, 1, 0);
        step(8'h00, 0, 7, 0, 0, 0, 0, 0);
        chk("lsh_m1", 32'(ReadData), 32'h4000);
        step(8'h80, 6, 0, 8, 1, 'h10, 1, 0);
        step(8'h00, 0, 8, 0, 0, 0, 0, 0);
        chk("lsh_m16", 32'(ReadData), 0);

        // Same-edge write and readout of R5
        step(8'hD0, 0, 0, 5, 1, 'h1111, 1, 0);
        step(8'hD0, 0, 5, 5, 1, 'h1234, 1, 0);
`ifdef REGFILE_BYPASS_EN
        chk("same_edge_rd", 32'(ReadData), 32'h1234);
`else
        chk("same_edge_rd", 32'(ReadData), 32'h1111);
`endif
        step(8'h00, 0, 5, 0, 0, 0, 0, 0);
        chk("same_edge_next", 32'(ReadData), 32'h1234);

        // Async reset while a write to R9 is pending
        step(8'h0B, 3, 0, 0, 1, 5, 1, 0);
        opc = 8'hD0; wa = 4'd9; src = 4'd9; ims = 1'b1; imm = 16'hABCD; we = 1'b1; rr = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        chk("async_readdata", 32'(ReadData), 0);
        chk("async_flags", 32'(Flags), 0);
        chk("async_aluout", 32'(AluOut), 32'hABCD);
        @(posedge clk);
        #1;
        chk("async_hold_rd", 32'(ReadData), 0);
        chk("async_hold_flags", 32'(Flags), 0);
        reset = 1'b0;
        step(8'h00, 0, 9, 0, 0, 0, 0, 0);
        chk("async_discard", 32'(ReadData), 0);

        // regReset overrides a same-edge write
        step(8'hD0, 0, 0, 10, 1, 'h8000, 1, 0);
        step(8'h0B, 0, 0, 0, 1, 1, 1, 0);
        step(8'hD0, 0, 10, 10, 1, 'h7777, 1, 1);
        chk("regreset_rd", 32'(ReadData), 0);
        chk("regreset_flags", 32'(Flags), 0);
        for (int i = 0; i < 16; i++) begin
            step(8'h00, 0, i, 0, 0, 0, 0, 0);
            chk("regreset_sweep", 32'(ReadData), 0);
        end

        // Random control words
        for (int k = 0; k < 500; k++) begin
            step(ops[$urandom_range(13)], int'($urandom_range(15)), int'($urandom_range(15)),
                 int'($urandom_range(15)), 1'($urandom_range(1)), $urandom_range(65535),
                 ($urandom_range(3) != 0), ($urandom_range(40) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
